// File: rtl/vga_scanout_if.sv
// vga_scanout_if: read port of the dual-port screen RAM.
// master issues address/enable; slave returns registered read data.
interface vga_scanout_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] o_Rd_Addr;
  logic              o_Rd_En;
  logic [DATA_W-1:0] i_Rd_Data;

  modport master (
    output o_Rd_Addr,
    output o_Rd_En,
    input  i_Rd_Data
  );

  modport slave (
    input  o_Rd_Addr,
    input  o_Rd_En,
    output i_Rd_Data
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing + framebuffer scan-out, 3-stage pipeline.
// Define VGA_SCANOUT_PIX_DOUBLE_EN for 2x2 pixel doubling.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 32,
  parameter int BPP      = 1,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [ADDR_W-1:0] i_Fb_Base,
  vga_scanout_if.master     rd,
  output logic              o_HSync,
  output logic              o_VSync,
  output logic              o_Active,
  output logic [BPP-1:0]    o_Pixel,
  output logic              o_Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PPW     = DATA_W / BPP;
  localparam int PSH     = $clog2(PPW);
  localparam int BSH     = $clog2(BPP);
  localparam int IDX_W   = (PPW > 1) ? PSH : 1;
`ifdef VGA_SCANOUT_PIX_DOUBLE_EN
  localparam int STRIDE  = (H_ACTIVE / 2) * BPP / DATA_W;
`else
  localparam int STRIDE  = H_ACTIVE * BPP / DATA_W;
`endif
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8))
  begin : g_bad_bpp
    $error("vga_scanout: BPP must be 1, 2, 4 or 8");
  end

  if ((DATA_W % BPP) != 0 ||
      ((H_ACTIVE * BPP) % DATA_W) != 0)
  begin : g_bad_width
    $error("vga_scanout: line must pack into whole words");
  end

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] line_base;

  logic              h_last;
  logic              v_last;
  logic              h_act;
  logic              v_act;
  logic              act0;
  logic              hs0;
  logic              vs0;
  logic              fs0;
  logic              line_adv;
  logic [HW-1:0]     x;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] addr0;
  logic [IDX_W-1:0]  idx0;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));
  assign h_act  = (h < HW'(H_ACTIVE));
  assign v_act  = (v < VW'(V_ACTIVE));
  assign act0   = h_act && v_act;
  assign fs0    = (h == '0) && (v == '0);

  assign hs0 = (h >= HW'(H_ACTIVE + H_FP)) &&
               (h <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs0 = (v >= VW'(V_ACTIVE + V_FP)) &&
               (v <  VW'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VGA_SCANOUT_PIX_DOUBLE_EN
  assign x        = h >> 1;
  assign line_adv = v_act && v[0];
`else
  assign x        = h;
  assign line_adv = v_act;
`endif

  // (0,0) must already see the freshly sampled base
  assign base0 = fs0 ? i_Fb_Base : frame_base;
  assign addr0 = base0 + line_base + ADDR_W'(x >> PSH);
  assign idx0  = IDX_W'(x) & IDX_W'(PPW - 1);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h          <= '0;
      v          <= '0;
      frame_base <= '0;
      line_base  <= '0;
    end else begin
      if (fs0) begin
        frame_base <= i_Fb_Base;
      end
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v         <= '0;
          line_base <= '0;
        end else begin
          v <= v + VW'(1);
          if (line_adv) begin
            line_base <= line_base + ADDR_W'(STRIDE);
          end
        end
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  logic             act1;
  logic             hs1;
  logic             vs1;
  logic             fs1;
  logic [IDX_W-1:0] idx1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rd.o_Rd_Addr <= '0;
      rd.o_Rd_En   <= 1'b0;
      act1         <= 1'b0;
      hs1          <= 1'b0;
      vs1          <= 1'b0;
      fs1          <= 1'b0;
      idx1         <= '0;
    end else begin
      rd.o_Rd_En <= act0;
      if (act0) begin
        rd.o_Rd_Addr <= addr0;
      end
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
      idx1 <= idx0;
    end
  end

  logic             act2;
  logic             hs2;
  logic             vs2;
  logic             fs2;
  logic [IDX_W-1:0] idx2;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      act2 <= 1'b0;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      fs2  <= 1'b0;
      idx2 <= '0;
    end else begin
      act2 <= act1;
      hs2  <= hs1;
      vs2  <= vs1;
      fs2  <= fs1;
      idx2 <= idx1;
    end
  end

  // leftmost pixel lives in the word's top bits
  logic [IDX_W-1:0] rev2;
  logic [BPP-1:0]   pix2;

  assign rev2 = IDX_W'(PPW - 1) - idx2;
  assign pix2 = BPP'(rd.i_Rd_Data >> (32'(rev2) << BSH));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Active      <= 1'b0;
      o_Pixel       <= '0;
      o_HSync       <= ~HS_ON;
      o_VSync       <= ~VS_ON;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Active      <= act2;
      o_Pixel       <= act2 ? pix2 : '0;
      o_HSync       <= hs2 ? HS_ON : ~HS_ON;
      o_VSync       <= vs2 ? VS_ON : ~VS_ON;
      o_Frame_Start <= fs2;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random framebuffer/base/reset stimulus against
// a position-arithmetic reference model of the scan-out.
module tb_vga_scanout;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int BPP = 2;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int HSP = 0;
  localparam int VSP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int F   = HT * VT;
`ifdef VGA_SCANOUT_PIX_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] fb_base;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [BPP-1:0] pixel;
  logic          frame_start;

  vga_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .BPP(BPP), .DATA_W(DW), .ADDR_W(AW),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Fb_Base     (fb_base),
    .rd            (ram_if),
    .o_HSync       (hsync),
    .o_VSync       (vsync),
    .o_Active      (active),
    .o_Pixel       (pixel),
    .o_Frame_Start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:65535];

  always @(posedge clk) begin
    if (ram_if.o_Rd_En) begin
      ram_if.i_Rd_Data <= mem[ram_if.o_Rd_Addr];
    end
  end

  int vectors = 0;
  int errors  = 0;
  int k       = 0;
  int base_of [0:15];
  logic [AW-1:0] last_addr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit in_act(int p);
    int f = p % F;
    return ((f % HT) < HA) && ((f / HT) < VA);
  endfunction

  function automatic int src_x(int p);
    int x = (p % F) % HT;
    return DBL ? x / 2 : x;
  endfunction

  function automatic logic [AW-1:0] word_addr(int p);
    int y  = (p % F) / HT;
    int sy = DBL ? y / 2 : y;
    int sw = (DBL ? HA / 2 : HA) * BPP / DW;
    int a  = base_of[p / F] + sy * sw + src_x(p) * BPP / DW;
    return AW'(a % 65536);
  endfunction

  function automatic logic [BPP-1:0] pix_of(int p);
    int sh = DW - BPP - (src_x(p) % (DW / BPP)) * BPP;
    logic [DW-1:0] w = mem[word_addr(p)];
    return BPP'(w >> sh);
  endfunction

  task automatic check_outputs();
    bit a;
    int p;
    int x;
    int y;
    a = (k >= 1) && in_act(k - 1);
    if (a) last_addr = word_addr(k - 1);
    chk("rd_en", 32'(ram_if.o_Rd_En), 32'(a));
    chk("rd_addr", 32'(ram_if.o_Rd_Addr), 32'(last_addr));
    if (k >= 3) begin
      p = k - 3;
      x = (p % F) % HT;
      y = (p % F) / HT;
      a = in_act(p);
      chk("active", 32'(active), 32'(a));
      chk("pixel", 32'(pixel), a ? 32'(pix_of(p)) : 32'd0);
      chk("hsync", 32'(hsync),
          (x >= HA + HFP && x < HA + HFP + HSW) ? HSP : 1 - HSP);
      chk("vsync", 32'(vsync),
          (y >= VA + VFP && y < VA + VFP + VSW) ? VSP : 1 - VSP);
      chk("frame_start", 32'(frame_start), 32'((p % F) == 0));
    end else begin
      chk("pipe_active", 32'(active), 0);
      chk("pipe_pixel", 32'(pixel), 0);
      chk("pipe_hsync", 32'(hsync), 1 - HSP);
      chk("pipe_vsync", 32'(vsync), 1 - VSP);
      chk("pipe_fs", 32'(frame_start), 0);
    end
  endtask

  task automatic run(int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_outputs();
      if ($urandom_range(0, 15) == 0) fb_base = AW'($urandom);
      if ((k % F) == 0) base_of[k / F] = int'(fb_base);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    k         = 0;
    last_addr = '0;
    fb_base   = AW'($urandom);
    base_of[0] = int'(fb_base);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(ram_if.o_Rd_En), 0);
    chk("rst_rd_addr", 32'(ram_if.o_Rd_Addr), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_hsync", 32'(hsync), 1 - HSP);
    chk("rst_vsync", 32'(vsync), 1 - VSP);
    chk("rst_fs", 32'(frame_start), 0);
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    rst_n   = 1'b0;
    fb_base = '0;
    repeat (3) @(negedge clk);
    release_reset();
    run(3 * F + 37);
    do_reset();
    run(2 * F + $urandom_range(20, 200));
    do_reset();
    run(3 * F);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Parametrised VGA scan-out engine. Generates H/V timing and framebuffer read addresses for a synchronous dual-port screen RAM (1-cycle registered read), and unpacks BPP-bit pixels from DATA_W-bit words.
- Sits between the pixel PLL and the DAC/colour pins. The SPI loader writes the RAM's other port.
- Generalises the fixed 640x480 1-bpp scan-out to arbitrary timing, pixel depth, sync polarity and a latched per-frame base address (page flipping).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 11, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 32, vertical back porch (lines)
BPP, 1, bits per pixel; one of 1, 2, 4, 8; DATA_W % BPP == 0
DATA_W, 8, RAM word width
ADDR_W, 16, RAM address width
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_Fb_Base  in  ADDR_W  framebuffer base word address; sampled once per frame
o_Rd_Addr  out  ADDR_W  RAM read address
o_Rd_En  out  1  RAM read enable
i_Rd_Data  in  DATA_W  RAM read data, valid 1 cycle after o_Rd_Addr/o_Rd_En
o_HSync  out  1  horizontal sync, level per HS_POL
o_VSync  out  1  vertical sync, level per VS_POL
o_Active  out  1  visible-region pixel strobe
o_Pixel  out  BPP  pixel value; 0 when o_Active=0
o_Frame_Start  out  1  one-cycle pulse marking pixel (0,0) at the outputs

Behaviour:
- Counters:
  - h: 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v: 0..V_TOTAL-1, defined likewise.
  - Order within a line/frame: active, front porch, sync, back porch.
  - v increments when h wraps; v wraps to 0 after V_TOTAL-1.
  - No off-by-one: exactly H_TOTAL clocks per line and V_TOTAL lines per frame.
- Reset: the async assert clears all state.
  - Counters = (0,0); o_HSync = ~HS_POL; o_VSync = ~VS_POL.
  - o_Active, o_Pixel, o_Rd_En, o_Rd_Addr, o_Frame_Start = 0.
  - Pipeline is flushed; the first clock after deassert processes position (0,0).
  - Reset mid-frame restarts at (0,0) with no partial-line output.
- Base latch: i_Fb_Base is captured into frame_base on the counter-stage cycle where h==0 and v==0. Changes at any other time have no effect until the next frame.
- Addressing (no multipliers):
  - STRIDE = H_ACTIVE*BPP/DATA_W words. line_base is cleared at frame start and advances by STRIDE at the end of each active line.
  - Word address = frame_base + line_base + (h*BPP)/DATA_W, modulo 2^ADDR_W (wrap silently).
  - Pixel select: MSB-first. The leftmost pixel of a word occupies bits [DATA_W-1 -: BPP].
- Pipeline: 3 stages. Outputs reflect counter position P three cycles after P is in the counters.
  - S1: o_Rd_Addr/o_Rd_En registered. o_Rd_En = 1 only for active positions; o_Rd_Addr holds its last value otherwise.
  - S2: RAM data returns; pixel index is carried alongside.
  - S3: o_Pixel, o_Active, o_HSync, o_VSync, o_Frame_Start registered together, so they are mutually aligned.
- Sync levels: o_HSync = HS_POL for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v.
- Blanking: o_Active = 1 iff h < H_ACTIVE and v < V_ACTIVE; o_Pixel forced to 0 otherwise.
- Static constraints: H_ACTIVE*BPP % DATA_W == 0. Illegal BPP triggers a simulation-time $error.

Optional Feature:
- Macro: VGA_SCANOUT_PIX_DOUBLE_EN.
- Defined:
  - Each source pixel is repeated for 2 horizontal clocks, and each source line is shown on 2 consecutive output lines.
  - Source x = h>>1, source y = v>>1; STRIDE = (H_ACTIVE/2)*BPP/DATA_W; line_base advances only after odd active lines.
  - Timing, sync outputs and latency are unchanged.
- Undefined: 1:1 mapping as described above. No extra logic.

Test Plan:
- Timing, defaults: 1 full frame. hsync low for 96 clocks starting 656 clocks after o_Active rises; line = 800 clocks; vsync low on lines 491-492; frame = 420000 clocks; exactly one o_Frame_Start per frame.
- Latency: H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, BPP=1, i_Fb_Base=0x0100, RAM model returns addr[7:0]. Expect o_Rd_Addr=0x0100 at S1 for (0,0); o_Pixel sequence on line 0 = bits of 0x00 MSB-first; line 1 reads 0x0101.
- BPP=4, DATA_W=8, word 0xA5 at base: o_Pixel = 0xA then 0x5 on consecutive active clocks; o_Rd_Addr increments every 2 clocks.
- Base latch: change i_Fb_Base 0x0000->0x4000 mid-frame. Reads stay at 0x0000+ until the next (0,0), then start at 0x4000.
- Reset mid-line at h=300, v=100: outputs go to reset values immediately (async). After deassert, o_Frame_Start pulses 3 clocks later and counters restart at (0,0).
- With VGA_SCANOUT_PIX_DOUBLE_EN, BPP=1, word 0x80: first two o_Pixel = 1, next 14 = 0; lines 0 and 1 read identical addresses; line 2 reads line_base + STRIDE.
